// File: rtl/mips_defs.sv
// Shared constants and loader state encoding for the loadable MIPS
// instruction memory.
package mips_defs;

    localparam int          NBITS     = 32;
    localparam int          NB_BYTE   = 8;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/ensamblador_palabra.sv
// Byte-to-word assembler: shifts bytes in MSB first and flags the cycle in
// which the last byte of a word arrives, presenting the full word alongside.
module ensamblador_palabra #(
    parameter int NBITS   = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_byte_valid,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic               o_word_valid,
    output logic [NBITS-1:0]   o_word
);

    localparam int NBYTES = NBITS / NB_BYTE;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int SW     = NBITS - NB_BYTE;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] shift_q, shift_d;
    logic          last_byte;

    // The final byte bypasses the register so the word is ready in the
    // same cycle it completes.
    assign last_byte    = (cnt_q == LAST);
    assign o_word_valid = i_byte_valid && last_byte && !i_clear;
    assign o_word       = {shift_q, i_byte};

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (i_clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (i_byte_valid) begin
            if (last_byte) begin
                cnt_d   = '0;
                shift_d = '0;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                shift_d = SW'({shift_q, i_byte});
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/memoria_instrucciones_cargable.sv
// Loadable instruction memory for the IF stage: registered fetch with fault
// flags, a byte-stream loader FSM and a synchronous debug readback port.
module memoria_instrucciones_cargable #(
    parameter int               NBITS     = mips_defs::NBITS,
    parameter int               CELDAS    = 256,
    parameter int               NB_BYTE   = mips_defs::NB_BYTE,
    parameter logic [NBITS-1:0] HALT_WORD = NBITS'(mips_defs::HALT_WORD)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_Step,
    input  logic [NBITS-1:0]          i_PC,
    output logic [NBITS-1:0]          o_Instruction,
    output logic                      o_Misaligned,
    output logic                      o_OutOfRange,
    input  logic                      i_LoadStart,
    input  logic                      i_ByteValid,
    input  logic [NB_BYTE-1:0]        i_Byte,
    output logic                      o_ByteReady,
    output logic                      o_Loading,
    output logic                      o_LoadDone,
    output logic                      o_Overflow,
    output logic [$clog2(CELDAS):0]   o_WordCount,
    input  logic [$clog2(CELDAS)-1:0] i_DirecDebug,
    output logic [NBITS-1:0]          o_DatoDebug
);

    import mips_defs::*;

    localparam int AW = $clog2(CELDAS);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(CELDAS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [NBITS-1:0] mem [CELDAS];

    loader_state_t    state_q, state_d;
    logic [CW-1:0]    ptr_q, ptr_d, ptr_inc;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [NBITS-1:0] instr_q, instr_d;
    logic             misal_q, misal_d;
    logic             oor_q, oor_d;
    logic [NBITS-1:0] dbg_q, dbg_d;

    logic             loading;
    logic             byte_take;
    logic             word_valid;
    logic [NBITS-1:0] word;
    logic [AW-1:0]    pc_idx;
    logic             pc_mis;
    logic             pc_oor;

    assign loading   = (state_q == LOAD);
    assign byte_take = loading && i_ByteValid && !i_LoadStart;

    ensamblador_palabra #(
        .NBITS   (NBITS),
        .NB_BYTE (NB_BYTE)
    ) u_ensamblador (
        .clk          (i_clk),
        .rst_n        (i_reset),
        .i_clear      (i_LoadStart),
        .i_byte_valid (byte_take),
        .i_byte       (i_Byte),
        .o_word_valid (word_valid),
        .o_word       (word)
    );

    // NOTE: the array has no reset so it maps onto RAM; a reset only
    // clears control state and leaves the loaded program intact.
    always_ff @(posedge i_clk) begin
        if (word_valid) begin
            mem[ptr_q[AW-1:0]] <= word;
        end
    end

    assign pc_idx = i_PC[AW+1:2];
    assign pc_mis = |i_PC[1:0];
    assign pc_oor = |i_PC[NBITS-1:AW+2];
    assign ptr_inc = ptr_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        if (i_LoadStart) begin
            state_d = LOAD;
            ptr_d   = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
        end else if (word_valid) begin
            ptr_d = ptr_inc;
            if (word == HALT_WORD) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else if (ptr_inc == CNT_FULL) begin
                state_d = DONE;
                done_d  = 1'b1;
                ovf_d   = 1'b1;
            end
        end
    end

    // Fetch is frozen during a load so the pipeline never sees a half-written
    // program; faulting fetches return a nop.
    always_comb begin
        instr_d = instr_q;
        misal_d = misal_q;
        oor_d   = oor_q;
        if (i_Step && !loading) begin
            misal_d = pc_mis;
            oor_d   = pc_oor;
            instr_d = (pc_mis || pc_oor) ? NBITS'(NOP) : mem[pc_idx];
        end
        dbg_d = mem[i_DirecDebug];
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            instr_q <= '0;
            misal_q <= 1'b0;
            oor_q   <= 1'b0;
            dbg_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            instr_q <= instr_d;
            misal_q <= misal_d;
            oor_q   <= oor_d;
            dbg_q   <= dbg_d;
        end
    end

    assign o_Instruction = instr_q;
    assign o_Misaligned  = misal_q;
    assign o_OutOfRange  = oor_q;
    assign o_ByteReady   = loading;
    assign o_Loading     = loading;
    assign o_LoadDone    = done_q;
    assign o_Overflow    = ovf_q;
    assign o_WordCount   = ptr_q;
    assign o_DatoDebug   = dbg_q;

endmodule

// File: doc/memoria_instrucciones_cargable.md
Name: memoria_instrucciones_cargable

Overview:
Parametrised successor instruction memory for the MIPS pipeline IF stage. It takes a byte-addressed PC and produces a registered instruction per step. It adds an on-chip byte-stream loader FSM with a valid/ready handshake, fed by the UART debug unit, replacing the edge-triggered debug write. It also adds a synchronous debug readback port and fetch fault flags for misaligned or out-of-range PCs.

Parameters:
NBITS, 32, instruction/word width in bits; must be a multiple of 8
CELDAS, 256, memory depth in words; power of two
NB_BYTE, 8, loader byte width
HALT_WORD, 32'hFFFFFFFF, sentinel word that terminates a load

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_Step  in  1  fetch enable (pipeline advance)
i_PC  in  NBITS  byte address of the instruction to fetch
o_Instruction  out  NBITS  registered fetched instruction
o_Misaligned  out  1  registered with the fetch: i_PC[1:0] != 0
o_OutOfRange  out  1  registered with the fetch: word index >= CELDAS
i_LoadStart  in  1  one-cycle pulse; starts or restarts a program load
i_ByteValid  in  1  loader byte valid
i_Byte  in  NB_BYTE  loader byte, MSB byte of each word first
o_ByteReady  out  1  loader ready to accept a byte
o_Loading  out  1  high while the FSM is in LOAD
o_LoadDone  out  1  level; high after a load completes, cleared by i_LoadStart
o_Overflow  out  1  load filled CELDAS words before HALT_WORD arrived
o_WordCount  out  $clog2(CELDAS)+1  number of words written by the last or current load
i_DirecDebug  in  $clog2(CELDAS)  debug readback word index
o_DatoDebug  out  NBITS  registered memory[i_DirecDebug]

Behaviour:
- Reset (i_reset=0, asynchronous): all outputs go to 0; the FSM goes to IDLE; byte counter, word pointer and assembly register are cleared. Memory contents are not affected by reset.
- FSM states:
  - IDLE -> LOAD on i_LoadStart.
  - LOAD -> DONE when a HALT_WORD is written, or when word pointer == CELDAS after a write.
  - DONE -> LOAD on i_LoadStart.
- i_LoadStart while in LOAD restarts the load: pointer=0, byte count=0, partial word discarded, o_Overflow=0, o_LoadDone=0.
- LOAD handshake:
  - o_ByteReady=1 throughout LOAD.
  - A byte transfers on any cycle with i_ByteValid && o_ByteReady.
  - Transferred bytes shift into the assembly register, MSB first.
- Word write: on the transfer of byte NBITS/NB_BYTE of a word, the assembled word is written to memory[pointer] in that same cycle. The pointer and o_WordCount then increment, and the byte count wraps to 0.
- Load termination:
  - If the written word == HALT_WORD, it is stored, counted, and the FSM enters DONE with o_LoadDone=1.
  - If the pointer reaches CELDAS without a HALT_WORD, the FSM enters DONE with o_LoadDone=1 and o_Overflow=1.
  - Memory words beyond the last written word keep their previous values.
- Fetch:
  - On a rising edge with i_Step=1 and FSM != LOAD, the block registers memory[i_PC[$clog2(CELDAS)+1:2]]. Latency is 1 cycle.
  - o_Misaligned and o_OutOfRange update in the same cycle as o_Instruction.
  - If either flag is set, o_Instruction=0 (nop).
  - Out of range means any i_PC bit above $clog2(CELDAS)+1 is set.
  - With i_Step=0, or during LOAD, o_Instruction and both flags hold their values.
- Debug readback: o_DatoDebug <= memory[i_DirecDebug] every cycle, 1-cycle latency, in all states. A read of the address being written in the same cycle returns the old data.
- The memory is a single-write-port, two-read-port synchronous array (distributed/BRAM-inferable); all writes come from the loader only.
- Reset mid-load: the FSM returns to IDLE; words already written stay in memory; o_WordCount reads 0.

Decomposition:
- Shared package/header (mips_defs): NBITS, NB_BYTE, HALT_WORD, the NOP encoding, and the loader state encodings (IDLE=2'd0, LOAD=2'd1, DONE=2'd2).
- One natural sub-module, ensamblador_palabra: the byte-to-word shift register and byte counter. It emits a one-cycle word_valid together with the assembled word.
- The memory array, FSM and fetch logic stay in the top module.

Test Plan:
- Reset load: drop i_reset mid-operation -> all outputs are 0, o_ByteReady=0, and a pre-loaded word is still readable via o_DatoDebug.
- Basic load: pulse i_LoadStart, then stream bytes 00 22 08 20, 12 34 56 78, FF FF FF FF -> memory[0]=32'h00220820, memory[1]=32'h12345678, memory[2]=HALT_WORD; o_WordCount=3, o_LoadDone=1, o_Overflow=0.
- Handshake gaps: same stream with i_ByteValid toggled 1/0 every cycle -> identical memory contents; no byte lost or duplicated.
- Fetch: after the load, i_Step=1 with i_PC=4 -> next cycle o_Instruction=32'h12345678; i_Step=0 with i_PC=0 -> output holds 32'h12345678.
- Faults: i_PC=6 -> o_Misaligned=1, o_Instruction=0; i_PC=CELDAS*4 -> o_OutOfRange=1, o_Instruction=0.
- Overflow/restart: with CELDAS=4, stream 5 non-halt words -> 4 words written, o_Overflow=1, o_LoadDone=1. Then i_LoadStart after 2 bytes plus 4 new bytes -> memory[0] holds the new word and o_WordCount=1.
